switch_box_config_loader: RTL

SWITCH_BOX_CONFIG_LOADER -- requirements
Module: switch_box_config_loader

---
 rtl/switch_box_config_loader.sv | 106 ++++++++++
 1 files changed

// File: rtl/switch_box_config_loader.sv
// Serial config loader for a chain of switch box elements, shadow frame plus commit.
// Optional even-parity frame check is enabled with macro CFG_PARITY_EN.
module switch_box_config_loader #(
    parameter int NUM_ELEMENTS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    input  logic                      cfg_bit,
    output logic                      cfg_ready,
    input  logic                      cfg_commit,
    input  logic                      cfg_clear,
    output logic                      cfg_full,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output logic [8*NUM_ELEMENTS-1:0] c_out
);

    localparam int TOTAL = 8*NUM_ELEMENTS;
`ifdef CFG_PARITY_EN
    localparam int FRAME = TOTAL + 1;
`else
    localparam int FRAME = TOTAL;
`endif
    localparam int CW = $clog2(FRAME+1);
    localparam logic [CW-1:0] TOT_C  = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_C = CW'(FRAME-1);

    typedef enum logic {LOAD, FULL} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [TOTAL-1:0] shadow;
`ifdef CFG_PARITY_EN
    logic             par;
    logic             err_q;
    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            shadow    <= '0;
            c_out     <= '0;
            cfg_ready <= 1'b1;
            cfg_full  <= 1'b0;
            cfg_done  <= 1'b0;
`ifdef CFG_PARITY_EN
            par       <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            cfg_done <= 1'b0;
            if (cfg_clear) begin
                // clear beats both a pending bit and a pending commit
                cnt       <= '0;
                state     <= LOAD;
                cfg_ready <= 1'b1;
                cfg_full  <= 1'b0;
            end else begin
                unique case (state)
                    LOAD: begin
                        if (cfg_valid) begin
                            if (cnt < TOT_C)
                                shadow <= {cfg_bit, shadow[TOTAL-1:1]};
`ifdef CFG_PARITY_EN
                            else
                                par <= cfg_bit;
`endif
                            cnt <= cnt + 1'b1;
                            if (cnt == LAST_C) begin
                                state     <= FULL;
                                cfg_ready <= 1'b0;
                                cfg_full  <= 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        if (cfg_commit) begin
                            cnt       <= '0;
                            state     <= LOAD;
                            cfg_ready <= 1'b1;
                            cfg_full  <= 1'b0;
`ifdef CFG_PARITY_EN
                            if (par == ^shadow) begin
                                c_out    <= shadow;
                                cfg_done <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
`else
                            c_out    <= shadow;
                            cfg_done <= 1'b1;
`endif
                        end
                    end
                    default: state <= LOAD;
                endcase
            end
        end
    end

endmodule
